tx_resp_scheduler: RTL and testbench

//  Schedules response traffic onto the single UART TX channel.
//  - Accepts RF read bytes and 16-bit ALU results.
//  - Buffers them as a byte stream in a small FIFO.
//  - Releases one byte per UART TX transaction, handshaking on UART_TX_Busy.
//  - Sits between the command controller's response outputs and the UART TX.

---
 rtl/tx_resp_scheduler.sv | 132 +++++++++++++
 tb/tb_tx_resp_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tx_resp_scheduler
//  Purpose  : Queues RF bytes and 16-bit ALU results as a byte stream and
//             releases them one at a time to the UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module tx_resp_scheduler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR   = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     RF_DATA,
    input  logic                 RF_VLD,
    input  logic [2*WIDTH-1:0]   ALU_DATA,
    input  logic                 ALU_VLD,
    input  logic                 UART_TX_Busy,
    output logic [WIDTH-1:0]     UART_TX_DATA,
    output logic                 UART_TX_VLD,
    output logic                 DROP_ERR,
    output logic [PTR:0]         FIFO_LEVEL
);

    localparam logic [PTR:0] c_depth = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] c_one   = (PTR+1)'(1);
    localparam logic [PTR:0] c_two   = (PTR+1)'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR-1:0]   r_wr_ptr;
    logic [PTR-1:0]   r_rd_ptr;
    logic [PTR:0]     r_level;
    logic             r_drop;
    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    state_t           r_state;

    logic [PTR:0]     w_free;
    logic [PTR:0]     w_free_after_alu;
    logic             w_alu_ok;
    logic             w_rf_ok;
    logic [PTR-1:0]   w_rf_idx;
    logic [PTR:0]     w_push_cnt;
    logic             w_pop;
    logic             w_drop;

    // Space is judged on the level at the start of the cycle; a same-cycle
    // pop never makes room for a push.
    always_comb begin
        w_free           = c_depth - r_level;
        w_alu_ok         = ALU_VLD && (w_free >= c_two);
        w_free_after_alu = w_alu_ok ? (w_free - c_two) : w_free;
        w_rf_ok          = RF_VLD && (w_free_after_alu >= c_one);
        w_rf_idx         = w_alu_ok ? (r_wr_ptr + PTR'(2)) : r_wr_ptr;
        w_push_cnt       = (w_alu_ok ? c_two : '0) + (w_rf_ok ? c_one : '0);
        w_pop            = (r_state == ST_REQ) && UART_TX_Busy;
        w_drop           = (ALU_VLD && !w_alu_ok) || (RF_VLD && !w_rf_ok);
    end

    always_ff @(posedge CLK) begin
        if (w_alu_ok) begin
            r_mem[r_wr_ptr]           <= ALU_DATA[WIDTH-1:0];
            r_mem[r_wr_ptr + PTR'(1)] <= ALU_DATA[2*WIDTH-1:WIDTH];
        end
        if (w_rf_ok) begin
            r_mem[w_rf_idx] <= RF_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_cnt[PTR-1:0];
            r_rd_ptr <= r_rd_ptr + {{(PTR-1){1'b0}}, w_pop};
            r_level  <= r_level + w_push_cnt - {{PTR{1'b0}}, w_pop};
            r_drop   <= w_drop;
        end
    end

    // Request is held until the transmitter acknowledges by raising Busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_level != '0) && !UART_TX_Busy) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_vld   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (UART_TX_Busy) begin
                        r_vld   <= 1'b0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!UART_TX_Busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign UART_TX_DATA = r_data;
    assign UART_TX_VLD  = r_vld;
    assign DROP_ERR     = r_drop;
    assign FIFO_LEVEL   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_tx_resp_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tx_resp_scheduler
//  Purpose  : Table-driven enqueue vectors plus a UART responder that checks
//             every transmitted byte against a push-order scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_resp_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RF_DATA;
    logic        RF_VLD;
    logic [15:0] ALU_DATA;
    logic        ALU_VLD;
    logic        force_busy = 1'b0;
    logic        resp_busy  = 1'b0;
    logic        UART_TX_Busy;
    logic [7:0]  UART_TX_DATA;
    logic        UART_TX_VLD;
    logic        DROP_ERR;
    logic [3:0]  FIFO_LEVEL;

    assign UART_TX_Busy = force_busy | resp_busy;

    tx_resp_scheduler #(.WIDTH(8), .DEPTH(8), .PTR(3)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RF_DATA      (RF_DATA),
        .RF_VLD       (RF_VLD),
        .ALU_DATA     (ALU_DATA),
        .ALU_VLD      (ALU_VLD),
        .UART_TX_Busy (UART_TX_Busy),
        .UART_TX_DATA (UART_TX_DATA),
        .UART_TX_VLD  (UART_TX_VLD),
        .DROP_ERR     (DROP_ERR),
        .FIFO_LEVEL   (FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    int         resp_dly    = 1;
    int         resp_hold   = 2;
    bit         resp_en     = 1'b0;
    bit         resp_active = 1'b0;
    int         txn_cnt     = 0;

    typedef struct {
        bit          alu_vld;
        logic [15:0] alu_data;
        bit          rf_vld;
        logic [7:0]  rf_data;
        bit          alu_acc;
        bit          rf_acc;
        logic [3:0]  exp_level;
        bit          exp_drop;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one strobe cycle and record accepted bytes in push order.
    task automatic drive(input bit av, input logic [15:0] ad, input bit rv, input logic [7:0] rd,
                         input bit aacc, input bit racc);
        @(negedge CLK);
        ALU_VLD  = av;
        ALU_DATA = ad;
        RF_VLD   = rv;
        RF_DATA  = rd;
        if (aacc) begin
            sb.push_back(ad[7:0]);
            sb.push_back(ad[15:8]);
        end
        if (racc) sb.push_back(rd);
        @(negedge CLK);
        ALU_VLD = 1'b0;
        RF_VLD  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !resp_active && FIFO_LEVEL == 4'd0 && UART_TX_VLD == 1'b0)
                done = 1'b1;
        end
        chk(name, done, 1'b1);
    endtask

    // UART model: acknowledges each request after resp_dly cycles and
    // holds Busy for resp_hold cycles.
    initial begin
        logic [7:0] cap;
        forever begin
            @(negedge CLK);
            if (resp_en && !force_busy && UART_TX_VLD === 1'b1) begin
                resp_active = 1'b1;
                cap = UART_TX_DATA;
                txn_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", cap);
                end else begin
                    chk("tx_byte", cap, sb.pop_front());
                end
                repeat (resp_dly) begin
                    @(negedge CLK);
                    chk("vld_hold", UART_TX_VLD, 1'b1);
                    chk("data_hold", UART_TX_DATA, cap);
                end
                resp_busy = 1'b1;
                @(negedge CLK);
                chk("vld_drop_on_busy", UART_TX_VLD, 1'b0);
                repeat (resp_hold - 1) begin
                    @(negedge CLK);
                    chk("vld_low_busy", UART_TX_VLD, 1'b0);
                end
                resp_busy = 1'b0;
                @(negedge CLK);
                chk("idle_gap", UART_TX_VLD, 1'b0);
                resp_active = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int t0;

        vt[0] = '{1'b1, 16'h1234, 1'b1, 8'h77, 1'b1, 1'b1, 4'd3, 1'b0};
        vt[1] = '{1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b1, 1'b0, 4'd5, 1'b0};
        vt[2] = '{1'b0, 16'h0000, 1'b1, 8'h5A, 1'b0, 1'b1, 4'd6, 1'b0};
        vt[3] = '{1'b0, 16'h0000, 1'b1, 8'h66, 1'b0, 1'b1, 4'd7, 1'b0};
        vt[4] = '{1'b1, 16'hCAFE, 1'b1, 8'h11, 1'b0, 1'b1, 4'd8, 1'b1};
        vt[5] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b0};
        vt[6] = '{1'b1, 16'h9999, 1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1};
        vt[7] = '{1'b0, 16'h0000, 1'b1, 8'h22, 1'b0, 1'b0, 4'd8, 1'b1};
        vt[8] = '{1'b1, 16'hA5A5, 1'b1, 8'h33, 1'b0, 1'b0, 4'd8, 1'b1};
        vt[9] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b0};

        RST = 1'b1; RF_VLD = 1'b0; RF_DATA = '0; ALU_VLD = 1'b0; ALU_DATA = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_vld", UART_TX_VLD, 1'b0);
        chk("rst_data", UART_TX_DATA, 8'h00);
        chk("rst_level", FIFO_LEVEL, 4'd0);
        chk("rst_drop", DROP_ERR, 1'b0);

        // Single RF byte: latency and hold-until-Busy
        resp_en = 1'b1; resp_dly = 3; resp_hold = 10;
        @(negedge CLK);
        RF_VLD = 1'b1; RF_DATA = 8'h5A; sb.push_back(8'h5A);
        @(negedge CLK);
        RF_VLD = 1'b0;
        chk("t1_level_after_push", FIFO_LEVEL, 4'd1);
        chk("t1_vld_not_yet", UART_TX_VLD, 1'b0);
        @(negedge CLK);
        chk("t1_vld_latency", UART_TX_VLD, 1'b1);
        wait_drain("t1_drain");
        chk("t1_txn_count", txn_cnt, 1);

        // ALU result: low byte first
        resp_dly = 2; resp_hold = 3;
        drive(1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_drain("t2_drain");
        chk("t2_txn_count", txn_cnt, 3);

        // Enqueue table with the transmitter held busy
        force_busy = 1'b1;
        resp_dly = 1; resp_hold = 2;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            ALU_VLD  = vt[i].alu_vld;
            ALU_DATA = vt[i].alu_data;
            RF_VLD   = vt[i].rf_vld;
            RF_DATA  = vt[i].rf_data;
            if (vt[i].alu_acc) begin
                sb.push_back(vt[i].alu_data[7:0]);
                sb.push_back(vt[i].alu_data[15:8]);
            end
            if (vt[i].rf_acc) sb.push_back(vt[i].rf_data);
            @(negedge CLK);
            ALU_VLD = 1'b0;
            RF_VLD  = 1'b0;
            chk($sformatf("vec%0d_level", i), FIFO_LEVEL, vt[i].exp_level);
            chk($sformatf("vec%0d_drop", i), DROP_ERR, vt[i].exp_drop);
            chk($sformatf("vec%0d_vld", i), UART_TX_VLD, 1'b0);
        end
        force_busy = 1'b0;
        wait_drain("table_drain");
        chk("table_txn_count", txn_cnt, 11);

        // Reset while a request is pending with 5 bytes queued
        resp_en = 1'b0;
        @(negedge CLK);
        drive(1'b1, 16'hAABB, 1'b1, 8'hCC, 1'b0, 1'b0);
        ALU_VLD = 1'b1; ALU_DATA = 16'hDDEE;
        @(negedge CLK);
        ALU_VLD = 1'b0;
        chk("t5_level_before", FIFO_LEVEL, 4'd5);
        chk("t5_vld_before", UART_TX_VLD, 1'b1);
        chk("t5_data_before", UART_TX_DATA, 8'hBB);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t5_vld_after", UART_TX_VLD, 1'b0);
        chk("t5_level_after", FIFO_LEVEL, 4'd0);
        chk("t5_data_after", UART_TX_DATA, 8'h00);
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (UART_TX_VLD !== 1'b0 || FIFO_LEVEL !== 4'd0) bad++;
        end
        chk("t5_quiet_after_rst", bad, 0);

        // Busy stuck high before the bytes arrive
        resp_en = 1'b1;
        force_busy = 1'b1;
        t0 = txn_cnt;
        drive(1'b1, 16'h1357, 1'b0, 8'h00, 1'b1, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (UART_TX_VLD !== 1'b0) bad++;
        end
        chk("t6_vld_while_busy", bad, 0);
        chk("t6_level_held", FIFO_LEVEL, 4'd2);
        force_busy = 1'b0;
        wait_drain("t6_drain");
        chk("t6_txn_count", txn_cnt - t0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
